// File: rtl/trace_pkg.sv
// Shared encodings and width helpers for the trace capture buffer.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CH_W   = 32;
  localparam int DEF_DEPTH  = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Fill needs one extra bit so that a full buffer (== depth) is representable.
  function automatic int fill_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store: synchronous write, registered read that holds
// its output until the next read enable.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // registered read port; output only changes on a read so the consumer sees stable data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/trace_capture_buffer.sv
// Circular trace capture with masked-compare trigger, post-trigger count and
// oldest-first ready/valid readout of the captured window.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                      ref_clk,
  input  logic                      reset,
  input  logic [NUM_CH*CH_W-1:0]    probe_data,
  input  logic                      probe_valid,
  input  logic                      arm,
  input  logic [$clog2(NUM_CH)-1:0] trig_ch,
  input  logic [CH_W-1:0]           trig_value,
  input  logic [CH_W-1:0]           trig_mask,
  input  logic [$clog2(DEPTH)-1:0]  post_count,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [NUM_CH*CH_W-1:0]    rd_data,
  output logic                      rd_last,
  output logic [1:0]                state,
  output logic [$clog2(DEPTH):0]    fill
);

  localparam int PW = ptr_w(DEPTH);
  localparam int FW = fill_w(DEPTH);
  localparam int DW = NUM_CH * CH_W;

  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [FW-1:0] FILL_ZERO = FW'(0);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  state_t          state_r, state_nx_s;
  logic [PW-1:0]   wr_ptr_r, remaining_r, post_lat_r;
  logic [PW-1:0]   rd_base_s, rd_addr_s;
  logic [FW-1:0]   fill_r, rd_cnt_r;
  logic            rd_valid_r, rd_last_r;
  logic [CH_W-1:0] ch_s [NUM_CH];
  logic [CH_W-1:0] trig_data_s;
  logic            match_s, capturing_s, wr_en_s, rd_en_s, transfer_s;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_s[k] = probe_data[k*CH_W +: CH_W];
  end

  assign trig_data_s = ch_s[trig_ch];
  assign match_s     = probe_valid && (((trig_data_s ^ trig_value) & trig_mask) == {CH_W{1'b0}});
  assign capturing_s = (state_r == ST_ARMED) || (state_r == ST_POST);
  assign wr_en_s     = capturing_s && probe_valid && !arm;
  assign transfer_s  = rd_valid_r && rd_ready;
  assign rd_en_s     = (state_r == ST_DONE) && !rd_valid_r && !arm;
  // Once the buffer has wrapped, the oldest entry is the one about to be overwritten.
  assign rd_base_s   = (fill_r == FILL_FULL) ? wr_ptr_r : PTR_ZERO;
  assign rd_addr_s   = rd_base_s + rd_cnt_r[PW-1:0];

  // next-state logic; arm overrides every other event
  always_comb begin
    state_nx_s = state_r;
    if (arm) begin
      state_nx_s = ST_ARMED;
    end else begin
      case (state_r)
        ST_IDLE: state_nx_s = ST_IDLE;
        ST_ARMED: begin
          if (match_s) begin
            state_nx_s = (post_lat_r == PTR_ZERO) ? ST_DONE : ST_POST;
          end else begin
            state_nx_s = ST_ARMED;
          end
        end
        ST_POST: begin
          if (probe_valid && (remaining_r == PTR_ONE)) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_POST;
          end
        end
        ST_DONE: begin
          if (transfer_s && rd_last_r) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // write pointer, fill, post-trigger countdown and read index
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= PTR_ZERO;
      fill_r      <= FILL_ZERO;
      remaining_r <= PTR_ZERO;
      post_lat_r  <= PTR_ZERO;
      rd_cnt_r    <= FILL_ZERO;
    end else if (arm) begin
      wr_ptr_r    <= PTR_ZERO;
      fill_r      <= FILL_ZERO;
      remaining_r <= PTR_ZERO;
      post_lat_r  <= post_count;
      rd_cnt_r    <= FILL_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        fill_r   <= (fill_r == FILL_FULL) ? fill_r : fill_r + FILL_ONE;
      end
      if ((state_r == ST_ARMED) && match_s) begin
        remaining_r <= post_lat_r;
      end else if ((state_r == ST_POST) && probe_valid) begin
        remaining_r <= remaining_r - PTR_ONE;
      end
      if (rd_en_s) begin
        rd_cnt_r <= rd_cnt_r + FILL_ONE;
      end
    end
  end

  // readout handshake: valid rises with each RAM read and drops on transfer
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else if (arm) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else if (rd_en_s) begin
      rd_valid_r <= 1'b1;
      rd_last_r  <= ((rd_cnt_r + FILL_ONE) == fill_r);
    end else if (transfer_s) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_valid_r;
      rd_last_r  <= rd_last_r;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_ram (
    .clk     (ref_clk),
    .rst_n   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (probe_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data)
  );

  assign rd_valid = rd_valid_r;
  assign rd_last  = rd_last_r;
  assign state    = state_r;
  assign fill     = fill_r;

endmodule
